// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA RAM port-A arbiter and its block engine.
package vga_arb_pkg;

    localparam int unsigned VGA_ADDR_W = 11;
    localparam int unsigned VGA_DATA_W = 32;
    localparam int unsigned VGA_WORDS  = 2048;

    localparam logic [3:0] WE_ALL  = 4'hF;
    localparam logic [3:0] WE_NONE = 4'h0;

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_COPY = 1'b1
    } op_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FILL   = 3'd1;
    localparam state_t ST_CP_RD  = 3'd2;
    localparam state_t ST_CP_CAP = 3'd3;
    localparam state_t ST_CP_WR  = 3'd4;
    localparam state_t ST_FIN    = 3'd5;

    // States in which the engine competes for the RAM port.
    function automatic logic engine_wants(input state_t st);
        return (st == ST_FILL) || (st == ST_CP_RD) || (st == ST_CP_WR);
    endfunction

endpackage

// File: rtl/vga_arb_addr_gen.sv
// Block-engine address generator: source/destination pointers, remaining count
// and copy direction, all stepping together and wrapping modulo the RAM depth.
module vga_arb_addr_gen
    import vga_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = VGA_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  op_t               op,
    input  logic [ADDR_W-1:0] src_init,
    input  logic [ADDR_W-1:0] dst_init,
    input  logic [ADDR_W:0]   len_init,
    input  logic              step,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic              last
);

    logic [ADDR_W-1:0] diff;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   remaining;
    logic              desc_d;
    logic              desc_q;

    // An overlapping copy towards higher addresses must run top-down so that
    // source words are read before they are overwritten.
    assign diff   = dst_init - src_init;
    assign span   = ADDR_W'(len_init - (ADDR_W+1)'(1));
    assign desc_d = (op == OP_COPY) && (dst_init > src_init)
                    && ({1'b0, diff} < len_init);

    always_ff @(posedge clk) begin
        if (rst) begin
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            desc_q    <= 1'b0;
        end else if (load) begin
            src       <= desc_d ? src_init + span : src_init;
            dst       <= desc_d ? dst_init + span : dst_init;
            remaining <= len_init;
            desc_q    <= desc_d;
        end else if (step) begin
            src       <= desc_q ? src - ADDR_W'(1) : src + ADDR_W'(1);
            dst       <= desc_q ? dst - ADDR_W'(1) : dst + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
        end
    end

    assign last = (remaining == (ADDR_W+1)'(1));

endmodule

// File: rtl/vga_ram_arbiter.sv
// VGA RAM port-A arbiter: CPU has priority, the FILL/COPY block engine uses idle cycles.
// Optional VGA_ARB_FAIRNESS_EN forces an engine grant after STARVE_LIMIT denied cycles.
module vga_ram_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = VGA_ADDR_W,
    parameter int unsigned DATA_W = VGA_DATA_W
`ifdef VGA_ARB_FAIRNESS_EN
    ,
    parameter int unsigned STARVE_LIMIT = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] buf_q;
    logic              load;
    logic              step;
    logic              cap;
    logic              eng_want;
    logic              eng_grant;
    logic              cpu_grant;
    logic [3:0]        eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic              last;

    vga_arb_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .op       (op_t'(cmd_op)),
        .src_init (cmd_src),
        .dst_init (cmd_dst),
        .len_init (cmd_len),
        .step     (step),
        .src      (src_ptr),
        .dst      (dst_ptr),
        .last     (last)
    );

    // Reset suppresses engine requests so an abort never lands a further write.
    assign eng_want = !rst && engine_wants(state);

`ifdef VGA_ARB_FAIRNESS_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic                force_eng;

    assign force_eng = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign eng_grant = eng_want && (!cpu_en || force_eng);
    assign cpu_stall = cpu_en && eng_want && force_eng;
    assign cpu_grant = cpu_en && !cpu_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (eng_grant) begin
            starve_cnt <= '0;
        end else if (eng_want && cpu_en) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    assign eng_grant = eng_want && !cpu_en;
    assign cpu_stall = 1'b0;
    assign cpu_grant = cpu_en;
`endif

    // Port-A mux; the RAM sees the winner in the same cycle.
    assign ram_en    = cpu_grant || eng_grant;
    assign ram_we    = cpu_grant ? cpu_we : (eng_grant ? eng_we : WE_NONE);
    assign ram_addr  = cpu_grant ? cpu_addr : eng_addr;
    assign ram_wdata = cpu_grant ? cpu_wdata : eng_wdata;
    assign cpu_rdata = ram_rdata;

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        cap        = 1'b0;
        eng_we     = WE_NONE;
        eng_addr   = dst_ptr;
        eng_wdata  = fill_q;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load = 1'b1;
                    if (cmd_len == '0) begin
                        next_state = ST_FIN;
                    end else if (op_t'(cmd_op) == OP_COPY) begin
                        next_state = ST_CP_RD;
                    end else begin
                        next_state = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                eng_we = WE_ALL;
                if (eng_grant) begin
                    step = 1'b1;
                    if (last) begin
                        next_state = ST_FIN;
                    end
                end
            end
            ST_CP_RD: begin
                eng_addr = src_ptr;
                if (eng_grant) begin
                    next_state = ST_CP_CAP;
                end
            end
            ST_CP_CAP: begin
                cap        = 1'b1;
                next_state = ST_CP_WR;
            end
            ST_CP_WR: begin
                eng_we    = WE_ALL;
                eng_wdata = buf_q;
                if (eng_grant) begin
                    step       = 1'b1;
                    next_state = last ? ST_FIN : ST_CP_RD;
                end
            end
            ST_FIN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == ST_IDLE);
            busy      <= (next_state != ST_IDLE);
            done      <= (next_state == ST_FIN);
        end
    end

    // Fill pattern is latched at accept; the copy buffer holds one word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
            buf_q  <= '0;
        end else begin
            if (load) begin
                fill_q <= cmd_data;
            end
            if (cap) begin
                buf_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed self-checking bench for vga_ram_arbiter with a behavioural port-A RAM.
module tb_vga_ram_arbiter;
    import vga_arb_pkg::*;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam int unsigned WORDS = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_en;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] cmd_data;
    logic          busy;
    logic          done;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [0:WORDS-1];
    logic          preload;
    int            wr_cnt = 0;
    int            en_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    vga_ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Port-A RAM: 1-cycle registered read, we[3] drives bits 7:0 ... we[0] bits 31:24.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= pat(i);
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][(3-b)*8 +: 8] <= ram_wdata[(3-b)*8 +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_en) en_cnt <= en_cnt + 1;
        if (ram_en && ram_we != 4'h0) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue_cmd(input logic op, input int src, input int dst, input int len,
                             input logic [31:0] data);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = AW'(src);
        cmd_dst   = AW'(dst);
        cmd_len   = (AW+1)'(len);
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Returns the cycle index (1 = cycle after accept) in which done is seen.
    task automatic wait_done(input int max_cyc, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic do_preload();
        @(posedge clk); #1; preload = 1'b1;
        @(posedge clk); #1; preload = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, bad, w0, e0, k, stalls, exp_stalls, exp_k;
        bit s;
        rst = 1'b1; preload = 1'b0;
        cpu_en = 1'b0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_data = '0;
        do_preload();
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_done",      64'(done),      64'(0));
        check("rst_stall",     64'(cpu_stall), 64'(0));
        check("rst_ram_en",    64'(ram_en),    64'(0));
        check("rst_ram_we",    64'(ram_we),    64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // FILL one text line
        issue_cmd(1'b0, 0, 0, 80, 32'h0720_0720);
        wait_done(200, cyc);
        check("fill_cycles", 64'(cyc), 64'(81));
        check("fill_busy_at_done", 64'(busy), 64'(1));
        bad = 0;
        for (int i = 0; i < 80; i++) if (mem[i] !== 32'h0720_0720) bad++;
        check("fill_words", 64'(bad), 64'(0));
        check("fill_w80", 64'(mem[80]), 64'(pat(80)));
        @(negedge clk);
        check("fill_idle_after", 64'({busy, done, cmd_ready}), 64'(3'b001));

        // COPY scroll-up by one line
        issue_cmd(1'b1, 80, 0, 1920, 32'h0);
        wait_done(6000, cyc);
        check("scroll_cycles", 64'(cyc), 64'(5761));
        bad = 0;
        for (int i = 0; i < 1920; i++) if (mem[i] !== pat(80 + i)) bad++;
        check("scroll_words", 64'(bad), 64'(0));
        check("scroll_tail", 64'(mem[2000]), 64'(pat(2000)));

        // overlapping COPY towards higher addresses
        do_preload();
        issue_cmd(1'b1, 10, 12, 8, 32'h0);
        wait_done(100, cyc);
        check("ovl_cycles", 64'(cyc), 64'(25));
        bad = 0;
        for (int i = 0; i < 8; i++) if (mem[12 + i] !== pat(10 + i)) bad++;
        check("ovl_words", 64'(bad), 64'(0));
        check("ovl_w11", 64'(mem[11]), 64'(pat(11)));
        check("ovl_w20", 64'(mem[20]), 64'(pat(20)));

        // full-RAM FILL starting near the top, wrapping
        w0 = wr_cnt;
        issue_cmd(1'b0, 0, 2040, 2048, 32'hDEAD_BEEF);
        wait_done(2200, cyc);
        check("wrap_cycles", 64'(cyc), 64'(2049));
        check("wrap_writes", 64'(wr_cnt - w0), 64'(2048));
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== 32'hDEAD_BEEF) bad++;
        check("wrap_words", 64'(bad), 64'(0));

        // zero-length command
        e0 = en_cnt;
        issue_cmd(1'b0, 0, 5, 0, 32'h1);
        wait_done(10, cyc);
        check("len0_cycles", 64'(cyc), 64'(1));
        check("len0_ram_en", 64'(en_cnt - e0), 64'(0));
        check("len0_w5", 64'(mem[5]), 64'(32'hDEAD_BEEF));

        // continuous CPU writes during a FILL
        do_preload();
        k = 0; stalls = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_dst = AW'(100); cmd_len = (AW+1)'(4);
        cmd_data = 32'h1111_1111;
        cpu_en = 1'b1; cpu_we = 4'hF; cpu_addr = AW'(200); cpu_wdata = 32'hC0DE_0000;
        for (int j = 0; j < 41; j++) begin
            @(negedge clk);
            s = cpu_stall;
            if (s) stalls++;
            @(posedge clk);
            if (!s) k++;
            #1;
            cmd_valid = 1'b0;
            cpu_addr  = AW'(200 + k);
            cpu_wdata = 32'hC0DE_0000 | 32'(k);
        end
        cpu_en = 1'b0; cpu_we = 4'h0;
`ifdef VGA_ARB_FAIRNESS_EN
        exp_stalls = 2; exp_k = 39;
        check("cpu_eng_w101", 64'(mem[101]), 64'(32'h1111_1111));
`else
        exp_stalls = 0; exp_k = 41;
        check("cpu_eng_w101", 64'(mem[101]), 64'(pat(101)));
`endif
        check("cpu_stalls", 64'(stalls), 64'(exp_stalls));
        check("cpu_writes", 64'(k), 64'(exp_k));
        check("cpu_eng_w102", 64'(mem[102]), 64'(pat(102)));
        check("cpu_eng_busy", 64'(busy), 64'(1));
        wait_done(20, cyc);
        bad = 0;
        for (int i = 100; i < 104; i++) if (mem[i] !== 32'h1111_1111) bad++;
        check("cpu_fill_words", 64'(bad), 64'(0));
        bad = 0;
        for (int i = 0; i < k; i++) if (mem[200 + i] !== (32'hC0DE_0000 | 32'(i))) bad++;
        check("cpu_data_words", 64'(bad), 64'(0));
        check("cpu_data_next", 64'(mem[200 + k]), 64'(pat(200 + k)));

        // byte-lane write then readbacks through cpu_rdata
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_we = 4'b1000; cpu_addr = AW'(300); cpu_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        cpu_we = 4'h0;
        @(posedge clk); #1;
        cpu_en = 1'b0;
        @(negedge clk);
        check("cpu_byte_rd", 64'(cpu_rdata), 64'(32'hA500_0144));
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_addr = AW'(205);
        @(posedge clk); #1;
        cpu_en = 1'b0;
        @(negedge clk);
        check("cpu_rd_205", 64'(cpu_rdata), 64'(32'hC0DE_0005));

        // reset during CP_WR of the 50th word of a 100-word copy
        issue_cmd(1'b1, 400, 600, 100, 32'h0);
        repeat (149) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        w0 = wr_cnt;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_ready", 64'(cmd_ready), 64'(1));
        check("abort_done", 64'(done), 64'(0));
        check("abort_ram_en", 64'(ram_en), 64'(0));
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_writes", 64'(wr_cnt - w0), 64'(0));
        check("abort_w600", 64'(mem[600]), 64'(pat(400)));
        check("abort_w648", 64'(mem[648]), 64'(pat(448)));
        check("abort_w650", 64'(mem[650]), 64'(pat(650)));
        check("abort_w660", 64'(mem[660]), 64'(pat(660)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_ram_arbiter.md
Name: vga_ram_arbiter

Overview:
- Owns port A of the dual-port VGA RAM (2048 x 32, 1-cycle registered read) and shares it between two requesters: the CPU bus and a built-in block engine.
- The block engine executes FILL and COPY commands so software can clear or scroll the screen without per-word stores.
- The CPU has priority. The engine uses idle cycles.
- Port B (scanout) is not touched.

Parameters:
ADDR_W, 11, word address width; RAM depth = 2**ADDR_W
DATA_W, 32, word width
STARVE_LIMIT, 15, consecutive denied engine cycles before a forced grant (fairness feature only)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
cpu_en  in  1  CPU access request this cycle
cpu_we  in  4  CPU byte write enables, RAM encoding (we[3]->bits 7:0 ... we[0]->bits 31:24)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data; valid the cycle after a granted CPU access
cpu_stall  out  1  CPU access not performed this cycle; hold request
cmd_valid  in  1  engine command offered
cmd_ready  out  1  engine idle, command accepted when valid&ready
cmd_op  in  1  0=FILL, 1=COPY
cmd_src  in  ADDR_W  COPY source start
cmd_dst  in  ADDR_W  destination start
cmd_len  in  ADDR_W+1  word count, 0..2048
cmd_data  in  DATA_W  FILL pattern
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
ram_en  out  1  to RAM enablea
ram_we  out  4  to RAM wea
ram_addr  out  ADDR_W  to RAM addra
ram_wdata  out  DATA_W  to RAM wda
ram_rdata  in  DATA_W  from RAM rda

Behaviour:
- Reset outputs: cmd_ready=1, busy=0, done=0, cpu_stall=0, ram_en=0, ram_we=0; state IDLE; counters 0.
- Arbitration and RAM drive:
  - RAM outputs are combinational muxes.
  - CPU granted whenever cpu_en=1.
  - Engine granted only when cpu_en=0.
  - cpu_rdata = ram_rdata passthrough.
  - Engine reads overwrite rda, so software must sample cpu_rdata exactly one cycle after its access.
- States: IDLE, FILL, CP_RD, CP_CAP, CP_WR, FIN.
- IDLE:
  - cmd_ready=1.
  - On accept, latch op/src/dst/len/data, then go to FIN if len=0, else FILL or CP_RD.
  - busy=1 from the cycle after accept until the cycle done pulses, inclusive.
- FILL:
  - Each granted cycle writes cmd_data (we=4'hF) to dst and decrements remaining.
  - Go to FIN after the last write.
- COPY:
  - CP_RD issues a read of src when granted (ram_en=1, we=0), then goes to CP_CAP.
  - CP_CAP captures ram_rdata into a buffer unconditionally; no RAM access by the engine (the CPU may use the cycle). Then goes to CP_WR.
  - CP_WR writes the buffer to dst when granted; if words remain, returns to CP_RD, else FIN.
  - Throughput: 3 cycles/word with no CPU traffic.
- Direction:
  - If dst > src (unsigned) and the regions overlap, the copy runs descending from src+len-1 / dst+len-1.
  - Otherwise it runs ascending.
  - The direction is decided at accept.
- Addresses wrap modulo 2**ADDR_W; len=2048 covers the full RAM exactly once.
- FIN: done=1 for one cycle, then IDLE.
- New commands are ignored while busy (cmd_ready=0).
- A stall in any engine state freezes the engine (no address or counter change).
- rst mid-command: abort at the next edge, no further engine writes, outputs return to reset values; a partially written region is left as is.

Optional Feature:
VGA_ARB_FAIRNESS_EN
- With it:
  - A starve counter increments each cycle the engine wants the RAM and is denied.
  - When it reaches STARVE_LIMIT, the engine wins the next cycle. cpu_stall=1 for that cycle, the CPU access is not performed, and the counter clears.
  - The counter also clears on any engine grant.
- Without it: cpu_stall is tied 0 and the CPU always wins; the engine may starve indefinitely.

Decomposition:
- Package vga_arb_pkg:
  - ADDR_W/DATA_W defaults and VGA_WORDS=2048
  - op enum {OP_FILL, OP_COPY}
  - state enum
  - WE_ALL=4'hF
- One natural sub-module, vga_arb_addr_gen: holds the src/dst pointers and remaining count, with an inc/dec direction, a step strobe, wrap, and a last flag.
- The arbiter FSM and mux stay at top level.

Test Plan:
- FILL dst=0, len=80, data=32'h0720_0720, no CPU traffic -> words 0..79 equal the pattern, 81 cycles accept-to-done, word 80 unchanged.
- COPY src=80, dst=0, len=1920 (scroll up one line) -> dst[i]=old src[i] for all i, done after 5760 cycles.
- Overlapping COPY src=10, dst=12, len=8 -> descending path, words 12..19 equal old words 10..17.
- FILL len=2048 with dst=2040 -> wraps, all 2048 words written once; len=0 -> done next cycle with no ram_en from the engine.
- CPU cpu_en=1 continuously during FILL -> engine makes no progress and CPU reads/writes are correct. With VGA_ARB_FAIRNESS_EN, cpu_stall pulses once every 16 cycles and the engine writes one word per pulse.
- rst asserted in CP_WR midway through len=100 -> no engine writes after reset, busy=0, cmd_ready=1 the next cycle.
